// File: rtl/toggle_chk_pkg.sv
// ============================================================================
// Module   : toggle_chk_pkg
// Brief    : Shared state encoding and sizing helper for toggle_checker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package toggle_chk_pkg;

  // 2'd3 is unused; the checker treats it as HUNT.
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter that holds at all-ones; clear has priority over inc.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/toggle_checker.sv
// ============================================================================
// Module   : toggle_checker
// Brief    : Lock/error monitor for an alternating 0/1 stream sampled on clk.
//            Define TOGGLE_CHK_CLR_EN to add the clr_err error-count clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module toggle_checker
  import toggle_chk_pkg::*;
#(
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
`ifdef TOGGLE_CHK_CLR_EN
  input  logic             clr_err,
`endif
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             exp_nxt
);

  localparam int CW = $clog2(max2(LOCK_CNT, UNLOCK_ERRS)) + 1;
  localparam logic [CW-1:0] C_LOCK_CNT    = CW'(LOCK_CNT);
  localparam logic [CW-1:0] C_UNLOCK_ERRS = CW'(UNLOCK_ERRS);

  state_t        r_state;
  logic          r_prev;
  logic [CW-1:0] r_good_cnt;
  logic [CW-1:0] r_bad_run;
  logic          w_good;
  logic          w_miss;
  logic          w_clr;
  logic [CW-1:0] w_good_nxt;
  logic [CW-1:0] w_bad_nxt;

  assign w_good     = (din != r_prev);
  assign w_miss     = (r_state == LOCK) && !w_good;
  assign w_good_nxt = r_good_cnt + CW'(1);
  assign w_bad_nxt  = r_bad_run + CW'(1);

`ifdef TOGGLE_CHK_CLR_EN
  assign w_clr = clr_err;
`else
  assign w_clr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= HUNT;
      r_prev     <= 1'b0;
      r_good_cnt <= '0;
      r_bad_run  <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      exp_nxt    <= 1'b0;
    end else begin
      r_prev  <= din;
      exp_nxt <= ~din;
      err     <= 1'b0;
      case (r_state)
        HUNT: begin
          r_state    <= ACQ;
          r_good_cnt <= '0;
        end
        ACQ: begin
          if (!w_good) begin
            r_good_cnt <= '0;
          end else if (w_good_nxt == C_LOCK_CNT) begin
            r_state    <= LOCK;
            locked     <= 1'b1;
            r_bad_run  <= '0;
            r_good_cnt <= '0;
          end else begin
            r_good_cnt <= w_good_nxt;
          end
        end
        LOCK: begin
          if (w_good) begin
            r_bad_run <= '0;
          end else begin
            err <= 1'b1;
            if (w_bad_nxt == C_UNLOCK_ERRS) begin
              r_state    <= ACQ;
              locked     <= 1'b0;
              r_good_cnt <= '0;
              r_bad_run  <= '0;
            end else begin
              r_bad_run <= w_bad_nxt;
            end
          end
        end
        default: begin
          r_state    <= HUNT;
          locked     <= 1'b0;
          r_good_cnt <= '0;
          r_bad_run  <= '0;
        end
      endcase
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .inc   (w_miss),
    .count (err_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_toggle_checker.sv
// ============================================================================
// Module   : tb_toggle_checker
// Brief    : Scoreboard bench for toggle_checker (ERR_W=2 to reach saturation).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_toggle_checker;

  localparam int LOCK_CNT    = 4;
  localparam int UNLOCK_ERRS = 2;
  localparam int ERR_W       = 2;
  localparam int SAT         = (1 << ERR_W) - 1;
`ifdef TOGGLE_CHK_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             clr_err = 1'b0;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic             exp_nxt;

  always #5 clk = ~clk;

  toggle_checker #(
    .LOCK_CNT    (LOCK_CNT),
    .UNLOCK_ERRS (UNLOCK_ERRS),
    .ERR_W       (ERR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
`ifdef TOGGLE_CHK_CLR_EN
    .clr_err (clr_err),
`endif
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt),
    .exp_nxt (exp_nxt)
  );

  typedef struct {
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] cnt;
    logic             exp;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: sample history since acquisition began, miss run, total misses.
  bit   m_have_prev = 0;
  bit   m_locked    = 0;
  bit   m_prev      = 0;
  bit   m_hist[$];
  int   m_miss_run  = 0;
  int   m_errs      = 0;

  function automatic bit window_alternates();
    if (m_hist.size() < LOCK_CNT + 1) return 1'b0;
    for (int i = 1; i < m_hist.size(); i++)
      if (m_hist[i] == m_hist[i-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input bit r, input bit d, input bit c);
    exp_t e;
    bit   pulse = 1'b0;
    if (r) begin
      m_have_prev = 0; m_locked = 0; m_prev = 0; m_miss_run = 0; m_errs = 0;
      m_hist.delete();
      e = '{locked: 1'b0, err: 1'b0, cnt: '0, exp: 1'b0};
    end else begin
      if (!m_have_prev) begin
        m_have_prev = 1;
        m_hist = {d};
      end else if (!m_locked) begin
        m_hist.push_back(d);
        if (m_hist.size() > LOCK_CNT + 1) void'(m_hist.pop_front());
        if (window_alternates()) begin
          m_locked   = 1;
          m_miss_run = 0;
        end
      end else if (d == m_prev) begin
        pulse = 1'b1;
        m_errs++;
        m_miss_run++;
        if (m_miss_run == UNLOCK_ERRS) begin
          m_locked   = 0;
          m_miss_run = 0;
          m_hist     = {d};
        end
      end else begin
        m_miss_run = 0;
      end
      if (CLR_EN && c) m_errs = 0;
      m_prev = d;
      e.locked = m_locked;
      e.err    = pulse;
      e.cnt    = ERR_W'((m_errs > SAT) ? SAT : m_errs);
      e.exp    = ~d;
    end
    expq.push_back(e);
  endtask

  task automatic step(input bit r, input bit d, input bit c);
    @(negedge clk);
    rst = r; din = d; clr_err = c;
    model(r, d, c);
  endtask

  task automatic alt(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ~m_prev, 1'b0);
  endtask

  task automatic miss(input bit c);
    step(1'b0, m_prev, c);
  endtask

  // Monitor: every edge the DUT presents a fresh registered response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_checks++;
        if (locked === e.locked && err === e.err && err_cnt === e.cnt && exp_nxt === e.exp)
          n_pass++;
        else
          $display("FAIL cycle_check t=%0t got locked=%b err=%b err_cnt=%0d exp_nxt=%b want locked=%b err=%b err_cnt=%0d exp_nxt=%b",
                   $time, locked, err, err_cnt, exp_nxt, e.locked, e.err, e.cnt, e.exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0);
    // lock acquisition: locked rises after the 5th edge
    step(0, 0, 0); step(0, 1, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    alt(3);
    miss(1'b0); alt(4);                    // isolated miss, stays locked
    miss(1'b0); miss(1'b0);                // two misses drop lock
    alt(LOCK_CNT); alt(2);                 // relock
    for (int i = 0; i < 5; i++) begin      // saturation at 3
      miss(1'b0); alt(2);
    end
    step(1'b1, 1'b0, 1'b0);                // reset while locked, err_cnt=3
    step(0, 1, 0);
    step(1'b1, 1'b0, 1'b0);
    step(0, 0, 0); alt(LOCK_CNT);
    miss(1'b0); alt(1); miss(1'b0); alt(1);
    miss(1'b1); alt(2);                    // clear coincident with miss
    for (int i = 0; i < 3000; i++) begin
      bit r, c, d;
      r = ($urandom_range(99) < 2);
      c = ($urandom_range(99) < 4);
      d = ($urandom_range(99) < 85) ? ~m_prev : m_prev;
      step(r, d, c);
    end
    step(0, ~m_prev, 0);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (expq.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending want 0", expq.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
